rfphoenix_thread_enqueue: RTL and testbench

Upstream feeder for the thread-ID FIFO in the rfPhoenix scheduler path. It watches a per-thread "ready" bitmap and selects one thread per cycle by rotating (round-robin) priority. It pushes that thread ID into the FIFO with a registered write strobe. It tracks which threads are already queued so that no thread ID is ever resident in the FIFO twice. It honours the FIFO's almost_full and full flags.

---
 rtl/rfphoenix_thread_enqueue_pkg.sv | 15 +
 rtl/rfphoenix_thread_enqueue_if.sv | 26 ++
 rtl/rfphoenix_thread_enqueue_rr_pick.sv | 31 +++
 rtl/rfphoenix_thread_enqueue.sv | 66 ++++++
 tb/tb_rfphoenix_thread_enqueue.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/rfphoenix_thread_enqueue_pkg.sv
// Shared scheduler types: thread count, thread-ID and per-thread bitmap widths.
// Also holds a small one-hot helper used by the enqueue logic.
package rfPhoenixPkg;

  localparam int NTHREAD = 8;
  localparam int TIDW    = $clog2(NTHREAD);

  typedef logic [TIDW-1:0]    tid_t;
  typedef logic [NTHREAD-1:0] thread_mask_t;

  function automatic thread_mask_t tid_onehot(input tid_t t);
    return thread_mask_t'(1) << t;
  endfunction

endpackage

// File: rtl/rfphoenix_thread_enqueue_if.sv
// Bundle between the thread-enqueue block and its environment.
// The master side drives the ready bitmap, done/flush and FIFO flags.
interface rfphoenix_thread_enqueue_if;

  rfPhoenixPkg::thread_mask_t req;
  logic                       done_v;
  rfPhoenixPkg::tid_t         done_tid;
  logic                       flush;
  logic                       fifo_almost_full;
  logic                       fifo_full;
  logic                       wr;
  rfPhoenixPkg::tid_t         di;
  rfPhoenixPkg::thread_mask_t queued;
  logic [31:0]                enq_count;

  modport master (
    output req, done_v, done_tid, flush, fifo_almost_full, fifo_full,
    input  wr, di, queued, enq_count
  );

  modport slave (
    input  req, done_v, done_tid, flush, fifo_almost_full, fifo_full,
    output wr, di, queued, enq_count
  );

endinterface

// File: rtl/rfphoenix_thread_enqueue_rr_pick.sv
// Round-robin picker: rotate the eligible mask so rr_ptr sits at bit 0,
// take the lowest set bit, then add rr_ptr back (wraps naturally in TIDW bits).
module rfphoenix_rr_pick
  import rfPhoenixPkg::*;
(
  input  thread_mask_t i_elig,
  input  tid_t         i_rr_ptr,
  output logic         o_pick_v,
  output tid_t         o_pick_tid
);

  thread_mask_t w_rot;
  tid_t         w_off;

  generate
    for (genvar gi = 0; gi < NTHREAD; gi++) begin : g_rot
      assign w_rot[gi] = i_elig[tid_t'(gi) + i_rr_ptr];
    end
  endgenerate

  always_comb begin
    w_off = '0;
    for (int i = NTHREAD - 1; i >= 0; i--) begin
      if (w_rot[i]) w_off = tid_t'(i);
    end
  end

  assign o_pick_v   = |w_rot;
  assign o_pick_tid = w_off + i_rr_ptr;

endmodule

// File: rtl/rfphoenix_thread_enqueue.sv
// Feeds ready thread IDs into the scheduler FIFO in round-robin order,
// never queueing a thread twice and backing off on almost_full/full.
module rfphoenix_thread_enqueue
  import rfPhoenixPkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  rfphoenix_thread_enqueue_if.slave bus
);

  logic         r_wr;
  tid_t         r_di;
  thread_mask_t r_queued;
  tid_t         r_rr_ptr;
  logic [31:0]  r_enq_count;

  thread_mask_t w_elig;
  thread_mask_t w_clr;
  thread_mask_t w_set;
  logic         w_pick_v;
  tid_t         w_pick_tid;
  logic         w_stall;
  logic         w_push;

  assign w_elig = bus.req & ~r_queued;

  rfphoenix_rr_pick u_pick (
    .i_elig     (w_elig),
    .i_rr_ptr   (r_rr_ptr),
    .o_pick_v   (w_pick_v),
    .o_pick_tid (w_pick_tid)
  );

  // almost_full leaves room for the push already registered on wr
  assign w_stall = bus.fifo_almost_full | bus.fifo_full;
  assign w_push  = w_pick_v & ~w_stall;
  assign w_clr   = bus.done_v ? tid_onehot(bus.done_tid) : '0;
  assign w_set   = w_push ? tid_onehot(w_pick_tid) : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr        <= 1'b0;
      r_di        <= '0;
      r_queued    <= '0;
      r_rr_ptr    <= '0;
      r_enq_count <= '0;
    end else if (bus.flush) begin
      r_queued <= '0;
      r_wr     <= 1'b0;
    end else begin
      r_queued <= (r_queued & ~w_clr) | w_set;
      r_wr     <= w_push;
      if (w_push) begin
        r_di        <= w_pick_tid;
        r_rr_ptr    <= w_pick_tid + tid_t'(1);
        r_enq_count <= r_enq_count + 32'd1;
      end
    end
  end

  assign bus.wr        = r_wr;
  assign bus.di        = r_di;
  assign bus.queued    = r_queued;
  assign bus.enq_count = r_enq_count;

endmodule

// File: tb/tb_rfphoenix_thread_enqueue.sv
// Bench for rfphoenix_thread_enqueue: directed scenarios plus a randomized run
// against a queue-based FIFO and a behavioural scheduling model.
module tb_rfphoenix_thread_enqueue;
  import rfPhoenixPkg::*;

  localparam int DEP = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;

  rfphoenix_thread_enqueue_if bus ();

  rfphoenix_thread_enqueue dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // reference model state
  logic         m_wr  = 1'b0;
  tid_t         m_di  = '0;
  thread_mask_t m_q   = '0;
  logic [31:0]  m_cnt = '0;
  int           m_ptr = 0;

  logic [43:0] obs;
  assign obs = {bus.wr, bus.di, bus.queued, bus.enq_count};

  task automatic drive_idle();
    bus.req = '0; bus.done_v = 1'b0; bus.done_tid = '0; bus.flush = 1'b0;
    bus.fifo_almost_full = 1'b0; bus.fifo_full = 1'b0;
  endtask

  task automatic model_clear();
    m_wr = 1'b0; m_di = '0; m_q = '0; m_cnt = '0; m_ptr = 0;
  endtask

  // advance one clock; the model applies the scheduling rules to the inputs in force
  task automatic cycle();
    int pick;
    if (rst) begin
      if (bus.flush) begin
        m_q = '0; m_wr = 1'b0;
      end else begin
        pick = -1;
        for (int k = 0; k < NTHREAD; k++) begin
          int t;
          t = (m_ptr + k) % NTHREAD;
          if (pick < 0 && bus.req[t] && !m_q[t]) pick = t;
        end
        if (bus.done_v) m_q[bus.done_tid] = 1'b0;
        if (pick >= 0 && !bus.fifo_almost_full && !bus.fifo_full) begin
          m_wr = 1'b1; m_di = tid_t'(pick); m_q[pick] = 1'b1;
          m_ptr = (pick + 1) % NTHREAD; m_cnt = m_cnt + 32'd1;
        end else begin
          m_wr = 1'b0;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  // asynchronous reset asserted mid-cycle, then released for the next edge
  task automatic do_reset();
    #2;
    rst = 1'b0;
    #1;
    n_checks++;
    if (obs !== 44'h0) $display("FAIL async_reset: got %h want %h", obs, 44'h0);
    else n_pass++;
    model_clear();
    drive_idle();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic test_reset();
    drive_idle();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (obs !== 44'h0) $display("FAIL reset_hold: got %h want %h", obs, 44'h0);
    else n_pass++;
    rst = 1'b1;
    model_clear();
  endtask

  task automatic test_single_push();
    bus.req = 8'b0000_0100;
    cycle();
    n_checks++;
    if (obs !== {1'b1, 3'd2, 8'h04, 32'd1}) $display("FAIL single_push: got %h want %h", obs, {1'b1, 3'd2, 8'h04, 32'd1});
    else n_pass++;
    cycle();
    n_checks++;
    if (obs !== {1'b0, 3'd2, 8'h04, 32'd1}) $display("FAIL single_idle: got %h want %h", obs, {1'b0, 3'd2, 8'h04, 32'd1});
    else n_pass++;
    bus.req = 8'hFF;
    cycle();
    do_reset();
  endtask

  task automatic test_round_robin();
    thread_mask_t exp_q;
    bus.req = 8'hFF;
    for (int i = 0; i < NTHREAD; i++) begin
      cycle();
      exp_q = thread_mask_t'((1 << (i + 1)) - 1);
      n_checks++;
      if (obs !== {1'b1, tid_t'(i), exp_q, 32'(i + 1)})
        $display("FAIL rr_push%0d: got %h want %h", i, obs, {1'b1, tid_t'(i), exp_q, 32'(i + 1)});
      else n_pass++;
    end
    cycle();
    n_checks++;
    if (obs !== {1'b0, 3'd7, 8'hFF, 32'd8}) $display("FAIL rr_full: got %h want %h", obs, {1'b0, 3'd7, 8'hFF, 32'd8});
    else n_pass++;
  endtask

  task automatic test_reenqueue();
    bus.done_v = 1'b1; bus.done_tid = 3'd3;
    cycle();
    n_checks++;
    if (obs !== {1'b0, 3'd7, 8'hF7, 32'd8}) $display("FAIL done_clear: got %h want %h", obs, {1'b0, 3'd7, 8'hF7, 32'd8});
    else n_pass++;
    bus.done_tid = 3'd5;
    cycle();
    n_checks++;
    if (obs !== {1'b1, 3'd3, 8'hDF, 32'd9}) $display("FAIL done_and_push: got %h want %h", obs, {1'b1, 3'd3, 8'hDF, 32'd9});
    else n_pass++;
    bus.done_v = 1'b0;
    cycle();
    n_checks++;
    if (obs !== {1'b1, 3'd5, 8'hFF, 32'd10}) $display("FAIL reenqueue5: got %h want %h", obs, {1'b1, 3'd5, 8'hFF, 32'd10});
    else n_pass++;
  endtask

  task automatic test_stall();
    do_reset();
    bus.req = 8'h0F;
    bus.fifo_almost_full = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cycle();
      n_checks++;
      if (obs !== 44'h0) $display("FAIL af_hold%0d: got %h want %h", i, obs, 44'h0);
      else n_pass++;
    end
    bus.fifo_almost_full = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cycle();
      n_checks++;
      if (obs !== {1'b1, tid_t'(i), thread_mask_t'((1 << (i + 1)) - 1), 32'(i + 1)})
        $display("FAIL af_release%0d: got %h want %h", i, obs, {1'b1, tid_t'(i), thread_mask_t'((1 << (i + 1)) - 1), 32'(i + 1)});
      else n_pass++;
    end
    bus.flush = 1'b1;
    cycle();
    bus.flush = 1'b0;
    n_checks++;
    if (obs !== {1'b0, 3'd3, 8'h00, 32'd4}) $display("FAIL stall_flush: got %h want %h", obs, {1'b0, 3'd3, 8'h00, 32'd4});
    else n_pass++;
    bus.fifo_full = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cycle();
      n_checks++;
      if (obs !== {1'b0, 3'd3, 8'h00, 32'd4}) $display("FAIL full_hold%0d: got %h want %h", i, obs, {1'b0, 3'd3, 8'h00, 32'd4});
      else n_pass++;
    end
    bus.fifo_full = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cycle();
      n_checks++;
      if (obs !== {1'b1, tid_t'(i), thread_mask_t'((1 << (i + 1)) - 1), 32'(i + 5)})
        $display("FAIL full_release%0d: got %h want %h", i, obs, {1'b1, tid_t'(i), thread_mask_t'((1 << (i + 1)) - 1), 32'(i + 5)});
      else n_pass++;
    end
  endtask

  task automatic test_flush();
    do_reset();
    bus.req = 8'h3C;
    repeat (4) cycle();
    n_checks++;
    if (obs !== {1'b1, 3'd5, 8'h3C, 32'd4}) $display("FAIL flush_setup: got %h want %h", obs, {1'b1, 3'd5, 8'h3C, 32'd4});
    else n_pass++;
    bus.req = 8'hFF; bus.flush = 1'b1; bus.done_v = 1'b1; bus.done_tid = 3'd2;
    cycle();
    bus.flush = 1'b0; bus.done_v = 1'b0;
    n_checks++;
    if (obs !== {1'b0, 3'd5, 8'h00, 32'd4}) $display("FAIL flush_prio: got %h want %h", obs, {1'b0, 3'd5, 8'h00, 32'd4});
    else n_pass++;
    cycle();
    n_checks++;
    if (obs !== {1'b1, 3'd6, 8'h40, 32'd5}) $display("FAIL flush_resume: got %h want %h", obs, {1'b1, 3'd6, 8'h40, 32'd5});
    else n_pass++;
    cycle();
    n_checks++;
    if (obs !== {1'b1, 3'd7, 8'hC0, 32'd6}) $display("FAIL flush_resume2: got %h want %h", obs, {1'b1, 3'd7, 8'hC0, 32'd6});
    else n_pass++;
  endtask

  task automatic test_random();
    tid_t        fifo_q[$];
    logic [31:0] pushes;
    bit          dup;
    do_reset();
    pushes = '0;
    for (int c = 0; c < 10000; c++) begin
      if (bus.wr) begin
        dup = 1'b0;
        foreach (fifo_q[j]) if (fifo_q[j] === bus.di) dup = 1'b1;
        n_checks++;
        if (dup || fifo_q.size() >= DEP)
          $display("FAIL fifo_push c%0d: got dup=%0b size=%0d want dup=0 size<%0d", c, dup, fifo_q.size(), DEP);
        else n_pass++;
        fifo_q.push_back(bus.di);
        pushes = pushes + 32'd1;
      end
      n_checks++;
      if (obs !== {m_wr, m_di, m_q, m_cnt}) $display("FAIL rand_model c%0d: got %h want %h", c, obs, {m_wr, m_di, m_q, m_cnt});
      else n_pass++;
      bus.req    = thread_mask_t'($urandom);
      bus.done_v = 1'b0;
      if (fifo_q.size() > 0 && $urandom_range(2) == 0) begin
        bus.done_v   = 1'b1;
        bus.done_tid = fifo_q.pop_front();
      end
      bus.fifo_almost_full = (fifo_q.size() >= DEP - 2);
      bus.fifo_full        = (fifo_q.size() >= DEP);
      cycle();
    end
    n_checks++;
    if (bus.enq_count !== pushes + 32'(bus.wr)) $display("FAIL enq_total: got %0d want %0d", bus.enq_count, pushes + 32'(bus.wr));
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single_push();
    test_round_robin();
    test_reenqueue();
    test_stall();
    test_flush();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
